// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types, address-split constants and store merge helpers for dcache_wb
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int LINES_DEF = 8;
    localparam int WORDS_DEF = 4;
    localparam int OB = $clog2(WORDS_DEF) + 2;
    localparam int IB = $clog2(LINES_DEF);
    localparam int TB = 32 - OB - IB;

    // A byte store replaces only lane addr[1:0] with the low data byte.
    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic        sb,
        input logic [1:0]  lane
    );
        logic [31:0] r_word;
        r_word = old_word;
        if (sb)
            r_word[lane*8 +: 8] = new_word[7:0];
        else
            r_word = new_word;
        return r_word;
    endfunction

    function automatic logic [3:0] byte_en(input logic sb, input logic [1:0] lane);
        logic [3:0] r_be;
        r_be = sb ? (4'b0001 << lane) : 4'b1111;
        return r_be;
    endfunction

endpackage

// File: rtl/dcache_array.sv
// rtl/dcache_array.sv - tag/valid/dirty/data storage, one combinational read port, one synchronous write port
module dcache_array #(
    parameter int LINES = 8,
    parameter int WORDS = 4,
    parameter int TW    = 25,
    parameter int IW    = 3,
    parameter int BW    = 2
) (
    input  logic          i_clk,
    input  logic          i_clear,
    input  logic [IW-1:0] i_rd_idx,
    input  logic [BW-1:0] i_rd_word,
    output logic [TW-1:0] o_tag,
    output logic          o_valid,
    output logic          o_dirty,
    output logic [31:0]   o_word,
    input  logic          i_we,
    input  logic [IW-1:0] i_wr_idx,
    input  logic [BW-1:0] i_wr_word,
    input  logic [31:0]   i_wdata,
    input  logic [3:0]    i_be,
    input  logic          i_tag_we,
    input  logic [TW-1:0] i_tag,
    input  logic          i_dirty_set
);

    logic [31:0]   r_data [0:LINES*WORDS-1];
    logic [TW-1:0] r_tag  [0:LINES-1];
    logic [LINES-1:0] r_valid;
    logic [LINES-1:0] r_dirty;

    assign o_tag   = r_tag[i_rd_idx];
    assign o_valid = r_valid[i_rd_idx];
    assign o_dirty = r_dirty[i_rd_idx];
    assign o_word  = r_data[{i_rd_idx, i_rd_word}];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_be[b])
                    r_data[{i_wr_idx, i_wr_word}][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
        end
        if (i_tag_we)
            r_tag[i_wr_idx] <= i_tag;
    end

    // Only the status bits are reset; tags and data are meaningless while invalid.
    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_tag_we) begin
            r_valid[i_wr_idx] <= 1'b1;
            r_dirty[i_wr_idx] <= 1'b0;
        end else if (i_dirty_set) begin
            r_dirty[i_wr_idx] <= 1'b1;
        end
    end

endmodule

// File: rtl/dcache_wb.sv
// rtl/dcache_wb.sv - direct-mapped write-back write-allocate data cache with miss FSM and hit/miss counters
module dcache_wb
    import dcache_pkg::*;
#(
    parameter int LINES          = LINES_DEF,
    parameter int WORDS_PER_LINE = WORDS_DEF,
    parameter int CNT_W          = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      cpu_addr,
    input  logic [31:0]      cpu_wdata,
    input  logic             cpu_read,
    input  logic             cpu_write,
    input  logic             cpu_sb,
    output logic [31:0]      cpu_rdata,
    output logic             stall,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             mem_read,
    output logic             mem_write,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_ready,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    localparam int L_OB = $clog2(WORDS_PER_LINE) + 2;
    localparam int L_IB = $clog2(LINES);
    localparam int L_TB = 32 - L_OB - L_IB;
    localparam int L_BB = L_OB - 2;
    localparam logic [L_BB-1:0] LAST_BEAT = L_BB'(WORDS_PER_LINE - 1);

    state_t            r_state;
    logic [L_BB-1:0]   r_beat;
    logic [L_TB-1:0]   r_tag;
    logic [L_IB-1:0]   r_index;
    logic [CNT_W-1:0]  r_hits;
    logic [CNT_W-1:0]  r_misses;

    logic [L_TB-1:0]   w_cpu_tag;
    logic [L_IB-1:0]   w_cpu_idx;
    logic [L_BB-1:0]   w_cpu_word;
    logic [1:0]        w_lane;
    logic              w_idle;
    logic              w_req;
    logic              w_present;
    logic              w_hit;
    logic              w_miss;
    logic [L_IB-1:0]   w_rd_idx;
    logic [L_BB-1:0]   w_rd_word;
    logic [L_TB-1:0]   w_line_tag;
    logic              w_line_valid;
    logic              w_line_dirty;
    logic [31:0]       w_line_word;
    logic              w_data_we;
    logic [31:0]       w_wdata;
    logic [3:0]        w_be;

    assign w_cpu_tag  = cpu_addr[31:L_OB+L_IB];
    assign w_cpu_idx  = cpu_addr[L_OB+L_IB-1:L_OB];
    assign w_cpu_word = cpu_addr[L_OB-1:2];
    assign w_lane     = cpu_addr[1:0];

    assign w_idle    = (r_state == IDLE);
    assign w_req     = cpu_read | cpu_write;
    assign w_present = w_line_valid && (w_line_tag == w_cpu_tag);
    assign w_hit     = w_idle && w_req && w_present;
    assign w_miss    = w_idle && w_req && !w_present;

    // Outside IDLE the array is addressed by the latched line and the beat counter.
    assign w_rd_idx  = w_idle ? w_cpu_idx  : r_index;
    assign w_rd_word = w_idle ? w_cpu_word : r_beat;

    assign w_data_we = (w_hit && cpu_write) || (r_state == FILL && mem_ready);
    assign w_wdata   = w_idle ? byte_merge(w_line_word, cpu_wdata, cpu_sb, w_lane) : mem_rdata;
    assign w_be      = w_idle ? byte_en(cpu_sb, w_lane) : 4'b1111;

    dcache_array #(
        .LINES (LINES),
        .WORDS (WORDS_PER_LINE),
        .TW    (L_TB),
        .IW    (L_IB),
        .BW    (L_BB)
    ) u_array (
        .i_clk       (clock),
        .i_clear     (reset),
        .i_rd_idx    (w_rd_idx),
        .i_rd_word   (w_rd_word),
        .o_tag       (w_line_tag),
        .o_valid     (w_line_valid),
        .o_dirty     (w_line_dirty),
        .o_word      (w_line_word),
        .i_we        (w_data_we),
        .i_wr_idx    (w_rd_idx),
        .i_wr_word   (w_rd_word),
        .i_wdata     (w_wdata),
        .i_be        (w_be),
        .i_tag_we    (r_state == DONE),
        .i_tag       (r_tag),
        .i_dirty_set (w_hit && cpu_write)
    );

    assign stall      = w_miss || !w_idle;
    assign cpu_rdata  = w_hit ? w_line_word : 32'd0;
    assign mem_write  = (r_state == WB);
    assign mem_read   = (r_state == FILL);
    assign mem_wdata  = (r_state == WB) ? w_line_word : 32'd0;
    assign mem_addr   = (r_state == WB)   ? {w_line_tag, r_index, r_beat, 2'b00} :
                        (r_state == FILL) ? {r_tag,      r_index, r_beat, 2'b00} : 32'd0;
    assign hit_count  = r_hits;
    assign miss_count = r_misses;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= IDLE;
            r_beat   <= '0;
            r_tag    <= '0;
            r_index  <= '0;
            r_hits   <= '0;
            r_misses <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_hit && r_hits != '1)
                        r_hits <= r_hits + 1'b1;
                    if (w_miss) begin
                        if (r_misses != '1)
                            r_misses <= r_misses + 1'b1;
                        r_tag   <= w_cpu_tag;
                        r_index <= w_cpu_idx;
                        r_beat  <= '0;
                        r_state <= (w_line_valid && w_line_dirty) ? WB : FILL;
                    end
                end
                WB: begin
                    if (mem_ready) begin
                        r_beat <= r_beat + 1'b1;
                        if (r_beat == LAST_BEAT)
                            r_state <= FILL;
                    end
                end
                FILL: begin
                    if (mem_ready) begin
                        r_beat <= r_beat + 1'b1;
                        if (r_beat == LAST_BEAT)
                            r_state <= DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_wb.sv
// tb/tb_dcache_wb.sv - directed self-checking bench for dcache_wb with a word-addressed backing memory model
module tb_dcache_wb;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_read, cpu_write, cpu_sb;
    logic        stall;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write, mem_ready;
    logic [15:0] hit_count, miss_count;

    int n_pass  = 0;
    int n_total = 0;
    int both_cnt = 0;

    logic [31:0] model [0:255];
    logic [31:0] log_addr [$];
    logic [31:0] log_data [$];
    logic        log_wr   [$];

    always #5 clock = ~clock;

    dcache_wb #(.LINES(8), .WORDS_PER_LINE(4), .CNT_W(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_read   (cpu_read),
        .cpu_write  (cpu_write),
        .cpu_sb     (cpu_sb),
        .cpu_rdata  (cpu_rdata),
        .stall      (stall),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    assign mem_rdata = model[mem_addr[9:2]];

    always @(posedge clock) begin
        if (mem_read && mem_write)
            both_cnt++;
        if (!reset && mem_ready && (mem_read || mem_write)) begin
            log_addr.push_back(mem_addr);
            log_data.push_back(mem_write ? mem_wdata : mem_rdata);
            log_wr.push_back(mem_write);
            if (mem_write)
                model[mem_addr[9:2]] = mem_wdata;
        end
    end

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        log_wr.delete();
    endtask

    // Presents one request, counts stalled cycles, returns the data seen on the completing cycle.
    task automatic access(input logic [31:0] a, input logic [31:0] wd, input logic rd,
                          input logic wr, input logic sb, output int nstall, output logic [31:0] rdv);
        @(negedge clock);
        cpu_addr = a; cpu_wdata = wd; cpu_read = rd; cpu_write = wr; cpu_sb = sb;
        #1;
        nstall = 0;
        while (stall && nstall < 200) begin
            nstall++;
            @(negedge clock);
            #1;
        end
        rdv = cpu_rdata;
        @(posedge clock);
        #1;
        cpu_read = 1'b0; cpu_write = 1'b0; cpu_sb = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_ready = 1'b1;
        cpu_addr = '0; cpu_wdata = '0; cpu_read = 1'b0; cpu_write = 1'b0; cpu_sb = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        n_total++; if (stall !== 1'b0) $display("FAIL reset_stall got %b want 0", stall); else n_pass++;
        n_total++; if (mem_read !== 1'b0) $display("FAIL reset_mem_read got %b want 0", mem_read); else n_pass++;
        n_total++; if (mem_write !== 1'b0) $display("FAIL reset_mem_write got %b want 0", mem_write); else n_pass++;
        n_total++; if (mem_addr !== 32'h0) $display("FAIL reset_mem_addr got %h want 0", mem_addr); else n_pass++;
        n_total++; if (mem_wdata !== 32'h0) $display("FAIL reset_mem_wdata got %h want 0", mem_wdata); else n_pass++;
        n_total++; if (cpu_rdata !== 32'h0) $display("FAIL reset_cpu_rdata got %h want 0", cpu_rdata); else n_pass++;
        n_total++; if (hit_count !== 16'd0) $display("FAIL reset_hits got %0d want 0", hit_count); else n_pass++;
        n_total++; if (miss_count !== 16'd0) $display("FAIL reset_misses got %0d want 0", miss_count); else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_cold_load();
        int ns; logic [31:0] rd;
        clear_log();
        access(32'h00, 32'h0, 1'b1, 1'b0, 1'b0, ns, rd);
        n_total++; if (ns != 6) $display("FAIL cold_stall_cycles got %0d want 6", ns); else n_pass++;
        n_total++; if (rd !== 32'h100) $display("FAIL cold_rdata got %h want 00000100", rd); else n_pass++;
        n_total++; if (log_addr.size() != 4) $display("FAIL cold_beat_count got %0d want 4", log_addr.size()); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            if (log_addr.size() > i) begin
                n_total++;
                if (log_addr[i] !== 32'(i*4) || log_wr[i] !== 1'b0)
                    $display("FAIL cold_beat%0d got addr %h wr %b want addr %h read", i, log_addr[i], log_wr[i], i*4);
                else n_pass++;
            end
        end
        n_total++; if (miss_count !== 16'd1) $display("FAIL cold_misses got %0d want 1", miss_count); else n_pass++;
        n_total++; if (hit_count !== 16'd1) $display("FAIL cold_hits got %0d want 1", hit_count); else n_pass++;
    endtask

    task automatic test_hit();
        int ns; logic [31:0] rd;
        access(32'h08, 32'h0, 1'b1, 1'b0, 1'b0, ns, rd);
        n_total++; if (ns != 0) $display("FAIL hit_stall got %0d want 0", ns); else n_pass++;
        n_total++; if (rd !== 32'h102) $display("FAIL hit_rdata got %h want 00000102", rd); else n_pass++;
        n_total++; if (hit_count !== 16'd2) $display("FAIL hit_hits got %0d want 2", hit_count); else n_pass++;
    endtask

    task automatic test_writeback();
        int ns; logic [31:0] rd;
        logic [31:0] exp_a [8];
        logic [31:0] exp_d [8];
        exp_a = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h80, 32'h84, 32'h88, 32'h8C};
        exp_d = '{32'h100, 32'hDEADBEEF, 32'h102, 32'h103, 32'h120, 32'h121, 32'h122, 32'h123};
        access(32'h04, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, ns, rd);
        n_total++; if (ns != 0) $display("FAIL store_hit_stall got %0d want 0", ns); else n_pass++;
        clear_log();
        access(32'h80, 32'h0, 1'b1, 1'b0, 1'b0, ns, rd);
        n_total++; if (ns != 10) $display("FAIL dirty_stall_cycles got %0d want 10", ns); else n_pass++;
        n_total++; if (rd !== 32'h120) $display("FAIL dirty_rdata got %h want 00000120", rd); else n_pass++;
        n_total++; if (log_addr.size() != 8) $display("FAIL dirty_beat_count got %0d want 8", log_addr.size()); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            if (log_addr.size() > i) begin
                n_total++;
                if (log_addr[i] !== exp_a[i] || log_data[i] !== exp_d[i] || log_wr[i] !== (i < 4))
                    $display("FAIL dirty_beat%0d got addr %h data %h wr %b want addr %h data %h wr %b",
                             i, log_addr[i], log_data[i], log_wr[i], exp_a[i], exp_d[i], (i < 4));
                else n_pass++;
            end
        end
        n_total++; if (miss_count !== 16'd2) $display("FAIL dirty_misses got %0d want 2", miss_count); else n_pass++;
        n_total++; if (hit_count !== 16'd4) $display("FAIL dirty_hits got %0d want 4", hit_count); else n_pass++;
    endtask

    task automatic test_byte_store();
        int ns; logic [31:0] rd;
        access(32'h80, 32'h11223344, 1'b0, 1'b1, 1'b0, ns, rd);
        access(32'h82, 32'h000000AA, 1'b0, 1'b1, 1'b1, ns, rd);
        access(32'h80, 32'h0, 1'b1, 1'b0, 1'b0, ns, rd);
        n_total++; if (rd !== 32'h11AA3344) $display("FAIL sb_merge got %h want 11aa3344", rd); else n_pass++;
        n_total++; if (hit_count !== 16'd7) $display("FAIL sb_hits got %0d want 7", hit_count); else n_pass++;
        clear_log();
        access(32'h00, 32'h0, 1'b1, 1'b0, 1'b0, ns, rd);
        n_total++; if (ns != 10) $display("FAIL sb_dirty_evict_stall got %0d want 10", ns); else n_pass++;
        n_total++;
        if (log_addr.size() < 1 || log_addr[0] !== 32'h80 || log_data[0] !== 32'h11AA3344)
            $display("FAIL sb_writeback_beat got %0d beats want first beat 80/11aa3344", log_addr.size());
        else n_pass++;
        n_total++; if (rd !== 32'h100) $display("FAIL sb_reload_rdata got %h want 00000100", rd); else n_pass++;
        n_total++; if (miss_count !== 16'd3) $display("FAIL sb_misses got %0d want 3", miss_count); else n_pass++;
    endtask

    task automatic test_ready_toggle();
        logic        rdy   [6];
        logic [31:0] exp_a [6];
        rdy   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        exp_a = '{32'h40, 32'h44, 32'h44, 32'h44, 32'h48, 32'h4C};
        @(negedge clock);
        cpu_addr = 32'h40; cpu_read = 1'b1; mem_ready = 1'b1;
        #1;
        n_total++; if (stall !== 1'b1 || mem_read !== 1'b0) $display("FAIL rt_miss_cycle got stall %b read %b want 1 0", stall, mem_read); else n_pass++;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            mem_ready = rdy[k];
            #1;
            n_total++;
            if (mem_read !== 1'b1 || mem_addr !== exp_a[k])
                $display("FAIL rt_fill_cycle%0d got read %b addr %h want 1 %h", k, mem_read, mem_addr, exp_a[k]);
            else n_pass++;
        end
        @(negedge clock);
        mem_ready = 1'b1;
        #1;
        n_total++; if (stall !== 1'b1 || mem_read !== 1'b0) $display("FAIL rt_done got stall %b read %b want 1 0", stall, mem_read); else n_pass++;
        @(negedge clock);
        #1;
        n_total++; if (stall !== 1'b0 || cpu_rdata !== 32'h110) $display("FAIL rt_complete got stall %b rdata %h want 0 00000110", stall, cpu_rdata); else n_pass++;
        @(posedge clock);
        #1;
        cpu_read = 1'b0;
    endtask

    task automatic test_reset_mid_fill();
        int ns; logic [31:0] rd;
        @(negedge clock);
        cpu_addr = 32'hC0; cpu_read = 1'b1; mem_ready = 1'b1;
        @(negedge clock);
        #1;
        n_total++; if (mem_read !== 1'b1 || mem_addr !== 32'hC0) $display("FAIL rmf_fill_start got read %b addr %h want 1 000000c0", mem_read, mem_addr); else n_pass++;
        @(negedge clock);
        reset = 1'b1; cpu_read = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        #1;
        n_total++; if (stall !== 1'b0) $display("FAIL rmf_stall got %b want 0", stall); else n_pass++;
        n_total++; if (mem_read !== 1'b0) $display("FAIL rmf_mem_read got %b want 0", mem_read); else n_pass++;
        n_total++; if (hit_count !== 16'd0 || miss_count !== 16'd0) $display("FAIL rmf_counters got %0d/%0d want 0/0", hit_count, miss_count); else n_pass++;
        access(32'hC0, 32'h0, 1'b1, 1'b0, 1'b0, ns, rd);
        n_total++; if (ns != 6) $display("FAIL rmf_remiss_stall got %0d want 6", ns); else n_pass++;
        n_total++; if (miss_count !== 16'd1) $display("FAIL rmf_remiss_count got %0d want 1", miss_count); else n_pass++;
        n_total++; if (rd !== 32'h130) $display("FAIL rmf_rdata got %h want 00000130", rd); else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 256; i++)
            model[i] = 32'h100 + 32'(i);
        test_reset();
        test_cold_load();
        test_hit();
        test_writeback();
        test_byte_store();
        test_ready_toggle();
        test_reset_mid_fill();
        n_total++; if (both_cnt != 0) $display("FAIL read_write_overlap got %0d cycles want 0", both_cnt); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dcache_wb.md
Name: dcache_wb

Overview:
- Direct-mapped, write-back, write-allocate data cache between the EX_MEM buffer outputs (MEM stage) and a backing data memory.
- Serves loads and stores in zero added cycles on a hit.
- On a miss it raises `stall`, which freezes PC, IF_ID, ID_EX and EX_MEM. It then writes back the dirty victim, refills the line beat by beat over a ready-handshaked memory port, and completes the access.
- Hit and miss counters feed the cache micro-benchmark.

Parameters:
- LINES, 8: number of cache lines; power of two, at least 2.
- WORDS_PER_LINE, 4: 32-bit words per line; power of two, at least 2.
- CNT_W, 16: width of the hit and miss counters.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- cpu_addr  in  32  byte address (ALU result from EX_MEM)
- cpu_wdata  in  32  store data
- cpu_read  in  1  load request (memtoReg path)
- cpu_write  in  1  store request (memWrite)
- cpu_sb  in  1  store-byte qualifier
- cpu_rdata  out  32  load data, aligned word
- stall  out  1  pipeline freeze
- mem_addr  out  32  word-aligned backing-memory address
- mem_wdata  out  32  write-back beat data
- mem_read  out  1  refill beat request
- mem_write  out  1  write-back beat request
- mem_rdata  in  32  refill beat data
- mem_ready  in  1  beat accepted or beat data valid
- hit_count  out  CNT_W  saturating hit counter
- miss_count  out  CNT_W  saturating miss counter

Behaviour:
- Address split: offset = addr[OB-1:0] with OB = log2(WORDS_PER_LINE)+2; index = next log2(LINES) bits; tag = remaining upper bits.
- Reset: all valid and dirty bits cleared; state IDLE; mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, stall=0, cpu_rdata=0; both counters 0. Data and tag RAM contents are don't-care.
- States:
  - IDLE: no transfer in progress; accepts CPU requests.
  - WB: writing back the dirty victim, beat counter 0..W-1.
  - FILL: refilling the line, beat counter 0..W-1.
  - DONE: one cycle; commits the new tag, sets valid, clears dirty.
- Request: `req = cpu_read | cpu_write`. If both are set, the access is treated as a write.
- Hit (IDLE, valid and tag match):
  - stall=0.
  - cpu_rdata is the addressed word, combinationally, in the same cycle.
  - A store updates the word at the posedge and sets dirty. With cpu_sb, only byte lane addr[1:0] is written, taking cpu_wdata[7:0].
  - hit_count +1 at the posedge. Counters saturate at all-ones.
- Miss (IDLE, req and not hit):
  - stall=1 combinationally in the same cycle; miss_count +1 at the posedge.
  - Next state: WB if the victim is valid and dirty, otherwise FILL.
- WB:
  - mem_write=1, mem_addr = {victim tag, index, beat, 2'b00}, mem_wdata = victim word[beat].
  - The beat advances on mem_ready; after the last beat the next state is FILL.
- FILL:
  - mem_read=1, mem_addr = {request tag, index, beat, 2'b00}.
  - On mem_ready, mem_rdata is written to word[beat] and the beat advances; after the last beat the next state is DONE.
- DONE: stall stays 1. The next cycle in IDLE is a hit: stall drops and the access completes there, including the store merge. The miss itself does not count as a hit.
- Miss penalty with a zero-wait memory (mem_ready tied 1): clean miss = W+2 stalled cycles; dirty miss = 2W+2.
- stall is 1 in every non-IDLE state. mem_read and mem_write are never both 1.
- mem_ready while neither mem_read nor mem_write is asserted is ignored.
- CPU inputs are held stable by the stall; changes to them outside IDLE are ignored. The request is latched at the miss.
- Reset mid-WB or mid-FILL: the transfer is abandoned, all lines are invalid, and backing memory may hold a partially written line (accepted).

Decomposition:
- Shared package `dcache_pkg`:
  - state enum {IDLE, WB, FILL, DONE}
  - localparams OB, IB, TB, derived via clog2
  - byte-merge function
- One sub-module, `dcache_array`: tag, valid, dirty and data storage, with one combinational read port and one synchronous write port with byte enables.
- `dcache_wb` holds the FSM, beat counter, latched request and counters.

Test Plan:
- Cold load from 0x00 with memory word n = 0x100+n, mem_ready=1:
  - stall high for 6 cycles (W+2);
  - beats issued at 0x00, 0x04, 0x08, 0x0C;
  - cpu_rdata=0x100;
  - miss_count=1, hit_count=1.
- Load 0x08 after the above → hit: stall=0, cpu_rdata=0x102, hit_count=2.
- Store 0xDEADBEEF to 0x04 (hit), then load 0x80 (same index, conflict):
  - 4 write-back beats with mem_addr 0x00..0x0C, the beat at 0x04 carrying 0xDEADBEEF;
  - then 4 refill beats from 0x80;
  - stall lasts 10 cycles.
- Byte store cpu_sb=1, addr 0x82, wdata 0x000000AA on a line holding 0x11223344 → word becomes 0x11AA3344, dirty=1.
- mem_ready toggling 1,0,0,1 during FILL → beats advance only on ready cycles; mem_addr is held while waiting.
- Reset asserted on the 2nd FILL beat → next cycle: stall=0, mem_read=0, both counters 0, and a load of the same address misses again.
